// File: rtl/out_demux_ms.sv
// Output demultiplexer for top_ms: steers tagged pixels into two per-flow FWFT FIFOs and pulses done per SIZE x SIZE block.
// Optional latency statistics (lat_first / lat_total) are built when OUT_DEMUX_STATS_EN is defined.
module out_demux_ms #(
    parameter int DEPTH = 16,
    parameter int FLUX  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8:0]             in_din,
    input  logic                   in_write,
    output logic [FLUX-1:0]        in_full,
    input  logic [7:0]             size_din,
    input  logic                   size_write,
    output logic [7:0]             out0_dout,
    output logic                   out0_valid,
    input  logic                   out0_ready,
    output logic [7:0]             out1_dout,
    output logic                   out1_valid,
    input  logic                   out1_ready,
    output logic [FLUX-1:0]        done,
    output logic                   err
`ifdef OUT_DEMUX_STATS_EN
    ,
    output logic [FLUX-1:0][31:0]  lat_first,
    output logic [FLUX-1:0][31:0]  lat_total
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    state_t          state     [FLUX];
    state_t          state_nxt [FLUX];
    logic [7:0]      mem       [FLUX][DEPTH];
    logic [AW-1:0]   wptr      [FLUX];
    logic [AW-1:0]   rptr      [FLUX];
    logic [AW:0]     count     [FLUX];
    logic [12:0]     target    [FLUX];
    logic [12:0]     pop_cnt   [FLUX];

    logic [FLUX-1:0] wr_sel, sz_sel, ready;
    logic [FLUX-1:0] idle, full, valid, push, pop, arm, finish;
    logic [6:0]      size;
    logic [12:0]     size_sq;
    logic            err_set;

    assign size    = size_din[6:0];
    assign size_sq = {6'd0, size} * {6'd0, size};
    assign wr_sel  = {in_write & in_din[8], in_write & ~in_din[8]};
    assign sz_sel  = {size_write & size_din[7], size_write & ~size_din[7]};
    assign ready   = {out1_ready, out0_ready};

    // Writes are only accepted while the flow is armed or running; pops are free-running on valid/ready.
    for (genvar g = 0; g < FLUX; g++) begin : g_flow
        assign idle[g]   = (state[g] == IDLE);
        assign full[g]   = (count[g] == FULL_CNT);
        assign valid[g]  = (count[g] != '0);
        assign push[g]   = wr_sel[g] & ~full[g] & ~idle[g];
        assign pop[g]    = valid[g] & ready[g];
        assign arm[g]    = sz_sel[g] & idle[g] & (size != 7'd0);
        assign finish[g] = (state[g] == RUN) & pop[g] & ((pop_cnt[g] + 13'd1) == target[g]);
    end

    assign err_set = (|(wr_sel & (full | idle))) | (|(sz_sel & ~idle)) | (size_write & (size == 7'd0));

    always_comb begin
        for (int f = 0; f < FLUX; f++) begin
            state_nxt[f] = state[f];
            unique case (state[f])
                IDLE:    if (arm[f])    state_nxt[f] = ARMED;
                ARMED:   if (push[f])   state_nxt[f] = RUN;
                RUN:     if (finish[f]) state_nxt[f] = IDLE;
                default:                state_nxt[f] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < FLUX; f++) begin
                state[f]   <= IDLE;
                wptr[f]    <= '0;
                rptr[f]    <= '0;
                count[f]   <= '0;
                target[f]  <= '0;
                pop_cnt[f] <= '0;
            end
            done <= '0;
            err  <= 1'b0;
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                state[f] <= state_nxt[f];
                if (push[f]) wptr[f] <= wptr[f] + 1'b1;
                if (pop[f])  rptr[f] <= rptr[f] + 1'b1;
                if (push[f] && !pop[f])      count[f] <= count[f] + 1'b1;
                else if (!push[f] && pop[f]) count[f] <= count[f] - 1'b1;
                if (arm[f]) target[f] <= size_sq;
                if (finish[f])                         pop_cnt[f] <= '0;
                else if (pop[f] && state[f] == RUN)    pop_cnt[f] <= pop_cnt[f] + 13'd1;
            end
            done <= finish;
            err  <= err | err_set;
        end
    end

    // Storage is not reset; valid gates dout so stale contents never reach the ports.
    always_ff @(posedge clk) begin
        for (int f = 0; f < FLUX; f++) begin
            if (push[f]) mem[f][wptr[f]] <= in_din[7:0];
        end
    end

    assign in_full    = full;
    assign out0_valid = valid[0];
    assign out1_valid = valid[1];
    assign out0_dout  = valid[0] ? mem[0][rptr[0]] : 8'd0;
    assign out1_dout  = valid[1] ? mem[1][rptr[1]] : 8'd0;

`ifdef OUT_DEMUX_STATS_EN
    logic [31:0] cyc [FLUX];

    // cyc reads 0 in the cycle after arming, so a capture at a pop edge equals cycles elapsed minus one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < FLUX; f++) begin
                cyc[f]       <= '0;
                lat_first[f] <= '0;
                lat_total[f] <= '0;
            end
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                if (arm[f]) begin
                    cyc[f]       <= '0;
                    lat_first[f] <= '0;
                    lat_total[f] <= '0;
                end else begin
                    if (!idle[f]) cyc[f] <= cyc[f] + 32'd1;
                    if (pop[f] && state[f] == RUN && pop_cnt[f] == 13'd0) lat_first[f] <= cyc[f];
                    if (finish[f]) lat_total[f] <= cyc[f];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_out_demux_ms.sv
// Scoreboard bench for out_demux_ms: stimulus queues expected pixels, a negedge monitor checks pops and done pulses.
module tb_out_demux_ms;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  in_din;
    logic        in_write;
    logic [1:0]  in_full;
    logic [7:0]  size_din;
    logic        size_write;
    logic [7:0]  out0_dout, out1_dout;
    logic        out0_valid, out1_valid;
    logic        out0_ready, out1_ready;
    logic [1:0]  done;
    logic        err;
`ifdef OUT_DEMUX_STATS_EN
    logic [1:0][31:0] lat_first, lat_total;
`endif

    always #5 clk = ~clk;

    out_demux_ms #(.DEPTH(16), .FLUX(2)) dut (
        .clk(clk), .rst(rst),
        .in_din(in_din), .in_write(in_write), .in_full(in_full),
        .size_din(size_din), .size_write(size_write),
        .out0_dout(out0_dout), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_dout(out1_dout), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .done(done), .err(err)
`ifdef OUT_DEMUX_STATS_EN
        , .lat_first(lat_first), .lat_total(lat_total)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int  mdl_target[2];
    int  mdl_pops[2];
    bit  mdl_active[2];
    bit  done_pend[2];
    int  done_seen[2];
    int  done_cyc[2];
    int  exp_done[2];
    int  cyc = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic popCheck(input int f, input logic [7:0] dout);
        logic [7:0] e;
        if ((f == 0 && exp0.size() == 0) || (f == 1 && exp1.size() == 0)) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL out%0d_unexpected_pop: got 0x%0h, expected no data", f, dout);
            return;
        end
        e = (f == 0) ? exp0.pop_front() : exp1.pop_front();
        checkOutput($sformatf("out%0d_data", f), 32'(dout), 32'(e));
        if (mdl_active[f]) begin
            mdl_pops[f]++;
            if (mdl_pops[f] == mdl_target[f]) begin
                done_pend[f]  = 1'b1;
                mdl_active[f] = 1'b0;
                mdl_pops[f]   = 0;
            end
        end
    endtask

    // Monitor: a pop seen here happens at the next posedge, so done is due at the following negedge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            for (int f = 0; f < 2; f++) begin
                if (done[f] || done_pend[f])
                    checkOutput($sformatf("done%0d_pulse", f), 32'(done[f]), 32'(done_pend[f]));
                if (done[f]) begin
                    done_seen[f]++;
                    done_cyc[f] = cyc;
                end
                done_pend[f] = 1'b0;
            end
            if (out0_valid && out0_ready) popCheck(0, out0_dout);
            if (out1_valid && out1_ready) popCheck(1, out1_dout);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [8:0] din, input logic sw, input logic [7:0] sdin);
        in_write   = wr;
        in_din     = din;
        size_write = sw;
        size_din   = sdin;
        tick();
        in_write   = 1'b0;
        size_write = 1'b0;
    endtask

    task automatic armFlow(input int f, input int sz, input bit accept);
        logic fb;
        fb = f[0];
        if (accept) begin
            mdl_target[f] = sz * sz;
            mdl_active[f] = 1'b1;
            mdl_pops[f]   = 0;
        end
        applyStimulus(1'b0, 9'h000, 1'b1, {fb, 7'(sz)});
    endtask

    task automatic writePix(input int f, input logic [7:0] pix, input bit accept);
        logic fb;
        fb = f[0];
        if (accept) begin
            if (f == 0) exp0.push_back(pix);
            else        exp1.push_back(pix);
        end
        applyStimulus(1'b1, {fb, pix}, 1'b0, 8'h00);
    endtask

    task automatic waitDone(input int f, input string name);
        exp_done[f]++;
        for (int i = 0; i < 1500 && done_seen[f] < exp_done[f]; i++) tick();
        checkOutput(name, 32'(done_seen[f]), 32'(exp_done[f]));
    endtask

    task automatic resetDut(input int n);
        rst        = 1'b1;
        in_write   = 1'b0;
        size_write = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        exp0.delete();
        exp1.delete();
        for (int f = 0; f < 2; f++) begin
            mdl_active[f] = 1'b0;
            mdl_pops[f]   = 0;
            done_pend[f]  = 1'b0;
        end
    endtask

    initial begin
        int n0;
        rst = 1'b1; in_din = '0; in_write = 1'b0; size_din = '0; size_write = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        for (int f = 0; f < 2; f++) begin
            mdl_active[f] = 0; mdl_pops[f] = 0; done_pend[f] = 0;
            done_seen[f] = 0; done_cyc[f] = 0; exp_done[f] = 0; mdl_target[f] = 0;
        end
        resetDut(3);
        checkOutput("rst_valid0", 32'(out0_valid), 32'd0);
        checkOutput("rst_valid1", 32'(out1_valid), 32'd0);
        checkOutput("rst_in_full", 32'(in_full), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);

        // Single flow: size 4 -> 16 pixels, first word visible one cycle after its write.
        out0_ready = 1'b1;
        armFlow(0, 4, 1);
        for (int i = 0; i < 16; i++) begin
            writePix(0, 8'(i), 1);
            if (i == 0) begin
                checkOutput("first_valid", 32'(out0_valid), 32'd1);
                checkOutput("first_dout", 32'(out0_dout), 32'h00);
            end
        end
        waitDone(0, "single_done");
        checkOutput("single_err", 32'(err), 32'd0);

        // Interleaved: flow 0 size 8 (64 px), flow 1 size 32 (1024 px).
        out1_ready = 1'b1;
        armFlow(0, 8, 1);
        armFlow(1, 32, 1);
        n0 = 0;
        for (int i = 0; i < 1024; i++) begin
            if (n0 < 64) begin
                writePix(0, 8'(n0 * 3), 1);
                n0++;
            end
            writePix(1, 8'(i) ^ 8'h5A, 1);
        end
        waitDone(0, "inter_done0");
        waitDone(1, "inter_done1");
        checkOutput("inter_done_order", 32'(done_cyc[0] < done_cyc[1]), 32'd1);
        checkOutput("inter_err", 32'(err), 32'd0);

        // Backpressure on flow 1 while flow 0 keeps streaming.
        out1_ready = 1'b0;
        armFlow(1, 4, 1);
        armFlow(0, 4, 1);
        for (int i = 0; i < 16; i++) writePix(1, 8'(8'hA0 + i), 1);
        checkOutput("bp_in_full", 32'(in_full), 32'h2);
        for (int i = 0; i < 16; i++) writePix(0, 8'(8'h30 + i), 1);
        waitDone(0, "bp_done0");
        checkOutput("bp_in_full_hold", 32'(in_full), 32'h2);
        checkOutput("bp_err_before", 32'(err), 32'd0);
        writePix(1, 8'hFF, 0);
        checkOutput("bp_err_overflow", 32'(err), 32'd1);
        out1_ready = 1'b1;
        checkOutput("bp_full_prepop", 32'(in_full[1]), 32'd1);
        tick();
        checkOutput("bp_full_cleared", 32'(in_full[1]), 32'd0);
        waitDone(1, "bp_done1");

        // Reset in the middle of a block clears data, flags and err.
        out0_ready = 1'b0;
        armFlow(0, 4, 1);
        for (int i = 0; i < 5; i++) writePix(0, 8'(i), 1);
        resetDut(10);
        checkOutput("midrst_valid0", 32'(out0_valid), 32'd0);
        checkOutput("midrst_in_full", 32'(in_full), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);

        // Write to an idle flow is dropped.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        writePix(1, 8'h77, 0);
        checkOutput("idle_wr_valid", 32'(out1_valid), 32'd0);
        checkOutput("idle_wr_err", 32'(err), 32'd1);

        // size_write to a running flow is ignored; the block still ends after 16 pops.
        resetDut(1);
        armFlow(0, 4, 1);
        writePix(0, 8'h10, 1);
        armFlow(0, 8, 0);
        checkOutput("run_sw_err", 32'(err), 32'd1);
        for (int i = 1; i < 16; i++) writePix(0, 8'(8'h10 + i), 1);
        waitDone(0, "run_sw_done");

        // Size 0 is rejected and the flow stays idle.
        resetDut(1);
        armFlow(1, 0, 0);
        checkOutput("size0_err", 32'(err), 32'd1);
        writePix(1, 8'h55, 0);
        checkOutput("size0_valid", 32'(out1_valid), 32'd0);

        // Full FIFO with a simultaneous pop: the write is dropped, in_full drops after the pop.
        resetDut(1);
        out0_ready = 1'b0;
        armFlow(0, 4, 1);
        for (int i = 0; i < 16; i++) writePix(0, 8'(8'hC0 + i), 1);
        checkOutput("full_in_full", 32'(in_full), 32'h1);
        checkOutput("full_err_before", 32'(err), 32'd0);
        out0_ready = 1'b1;
        writePix(0, 8'hEE, 0);
        checkOutput("full_pop_in_full", 32'(in_full), 32'h0);
        checkOutput("full_pop_err", 32'(err), 32'd1);
        waitDone(0, "full_done");

        // size_write coinciding with the final pop is rejected.
        resetDut(1);
        out0_ready = 1'b0;
        armFlow(0, 4, 1);
        for (int i = 0; i < 16; i++) writePix(0, 8'(8'h60 + i), 1);
        checkOutput("collide_err_before", 32'(err), 32'd0);
        out0_ready = 1'b1;
        repeat (15) tick();
        armFlow(0, 4, 0);
        checkOutput("collide_err", 32'(err), 32'd1);
        waitDone(0, "collide_done");
        writePix(0, 8'h99, 0);
        checkOutput("collide_idle_valid", 32'(out0_valid), 32'd0);

        // Back-to-back blocks: re-arm in the cycle done is high.
        resetDut(1);
        out0_ready = 1'b1;
        armFlow(0, 4, 1);
        for (int i = 0; i < 16; i++) writePix(0, 8'(i) ^ 8'h3C, 1);
        for (int i = 0; i < 50 && done[0] !== 1'b1; i++) tick();
        armFlow(0, 4, 1);
        waitDone(0, "b2b_done1");
        checkOutput("b2b_err_arm", 32'(err), 32'd0);
        for (int i = 0; i < 16; i++) writePix(0, 8'(8'h80 + i), 1);
        waitDone(0, "b2b_done2");
        checkOutput("b2b_err", 32'(err), 32'd0);

`ifdef OUT_DEMUX_STATS_EN
        resetDut(1);
        out0_ready = 1'b1;
        armFlow(0, 4, 1);
        repeat (5) tick();
        for (int i = 0; i < 16; i++) writePix(0, 8'(i), 1);
        waitDone(0, "stats_done");
        checkOutput("stats_lat_first", lat_first[0], 32'd6);
        checkOutput("stats_lat_total", lat_total[0], 32'd21);
`endif

        for (int i = 0; i < 200 && (exp0.size() > 0 || exp1.size() > 0); i++) tick();
        checkOutput("drain_q0", 32'(exp0.size()), 32'd0);
        checkOutput("drain_q1", 32'(exp1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/out_demux_ms.md
# out_demux_ms

Output demultiplexer placed directly downstream of the multi-stream interpolation core `top_ms`. It accepts the core's tagged 9-bit output write stream, where bit 8 is the flow id. It steers each pixel into one of two per-flow FIFOs, which are drained through independent valid/ready ports, and raises a per-flow `done` pulse after the last pixel of each SIZE×SIZE output block is delivered.

## Interface
Parameters:
- `DEPTH`, 16: entries per flow FIFO; power of two, ≥2
- `FLUX`, 2: number of flows; fixed at 2, because the tag is one bit

Ports:
- `clk` in 1: single clock, all logic on the rising edge
- `rst` in 1: synchronous, active-high reset
- `in_din` in 9: {flow tag, pixel[7:0]} from the core output write port
- `in_write` in 1: write strobe from the core
- `in_full` out 2: per-flow full back to the core; bit f = FIFO f full
- `size_din` in 8: {flow tag, output block size[6:0]}; legal sizes are 4, 8, 16, 32, 64
- `size_write` in 1: arms the tagged flow with a block size
- `out0_dout` / `out1_dout` out 8: flow 0/1 pixel
- `out0_valid` / `out1_valid` out 1: pixel available
- `out0_ready` / `out1_ready` in 1: consumer accepts
- `done` out 2: one-cycle pulse per flow at block completion
- `err` out 1: sticky protocol-error flag, cleared only by `rst`

## Operation
- Each flow f has its own FSM with states IDLE, ARMED, RUN.
  - IDLE → ARMED on `size_write` with tag f and size ≠0. The FSM latches target = size×size into a 13-bit register (max 4096).
  - ARMED → RUN on the first accepted `in_write` for flow f.
  - RUN → IDLE when the pop counter reaches target. `done[f]` pulses on the same transition.
- Push rule: a word is pushed into FIFO[in_din[8]] when `in_write`=1 and `in_full[tag]`=0. The pushed word is in_din[7:0].
- Drop rules:
  - A write to a full FIFO is dropped and sets `err`.
  - A write for a flow in IDLE is dropped and sets `err`.
- Size-write rules:
  - A `size_write` to a non-IDLE flow is ignored and sets `err`.
  - A `size_write` with size 0 is ignored and sets `err`.
- Pop rule: a word is popped when `outf_valid`=1 and `outf_ready`=1. The 13-bit pop counter increments on each pop and is cleared on the RUN→IDLE transition.
- Flow independence: a stalled consumer on one flow never blocks the other. Only its own `in_full` bit asserts.
- FIFOs use read/write pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus an occupancy count of log2(DEPTH)+1 bits.
- `in_full[f]` = (count_f == DEPTH).
- `outf_valid` = (count_f ≠ 0).
- Output is first-word-fall-through: `outf_dout` shows the head entry whenever valid.

## Timing
- Reset values:
  - `in_full`=00, `out0_valid`=`out1_valid`=0, `done`=00, `err`=0.
  - `dout` values are don't-care but are driven to 0.
  - Both FSMs go to IDLE; pointers, counts and pop counters go to 0.
- Latency: a word pushed at edge N is visible (`valid`=1, `dout`=word) after edge N, i.e. in cycle N+1.
- Simultaneous push and pop on the same FIFO:
  - Count is unchanged.
  - When the FIFO is empty, no bypass occurs: the pushed word appears the next cycle.
  - When the FIFO is full, the push is dropped because `in_full` was already 1. The pop still completes, and `in_full` drops the next cycle.
- `done[f]` is high for exactly the one cycle following the edge where the last pixel was popped. `outf_valid` may remain high if further data is buffered.
- Back-to-back blocks: `size_write` is accepted in the cycle `done[f]` is high, since the FSM is then in IDLE.
- A `size_write` in the same cycle as the final pop is rejected and sets `err`.
- Reset mid-operation discards all buffered data and counters on the next edge.

## Configuration
- `OUT_DEMUX_STATS_EN` defined:
  - Adds per-flow 32-bit outputs `lat_first[f]` and `lat_total[f]`.
  - The counters are cleared on IDLE→ARMED and count cycles from the arming edge to the first pop and to the final pop respectively.
  - Values are held until re-armed; reset value is 0.
- Undefined: these ports and counters are absent, and all other behaviour is identical.

## Test plan
- Reset: assert `rst` for 10 cycles mid-stream → the next cycle shows `valid`=0, `in_full`=00, `done`=00, `err`=0.
- Single flow: arm flow 0 with size 4, write 16 pixels 0x00..0x0F, `out0_ready`=1 → out0 delivers 0x00..0x0F in order, first word one cycle after the first write, `done`=01 for one cycle after the 16th pop, flow 0 returns to IDLE.
- Interleaved flows: arm flow 0 with 8 and flow 1 with 32, alternate tags per write → out0 gets 64 pixels and out1 gets 1024, each in order; `done[0]` precedes `done[1]`; `err`=0.
- Backpressure: `out1_ready`=0 with DEPTH=16 → `in_full[1]`=1 after 16 writes, flow 0 keeps streaming; a 17th flow-1 write sets `err`; raising `out1_ready` clears `in_full[1]` one cycle after the first pop.
- Protocol errors: a write to an IDLE flow → word dropped, `err`=1; `size_write` to a RUN flow → ignored, target unchanged; a size-0 write → ignored.
- Stats (`OUT_DEMUX_STATS_EN`): arm, wait 5 cycles, then stream 16 pixels with `ready`=1 → `lat_first`=6 and `lat_total`=21.
